fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 123 ++++++++++++
 tb/tb_fetch_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with in-order prefetch FIFO and redirect discard.
// Optional macro FETCH_PC_PLUS8_EN: pc reports the fetch address + 8 (ARM R15 view).
module fetch_stage #(
  parameter int unsigned   N        = 32,
  parameter logic [N-1:0]  RESET_PC = 32'h0000_0000,
  parameter int unsigned   DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [N-1:0] imem_rdata,
  output logic [N-1:0] inst,
  output logic [N-1:0] pc,
  output logic         inst_valid,
  input  logic         deco_ready,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam int unsigned   CW       = AW + 1;
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
  localparam logic [N-1:0]  LP_STEP  = N'(4);

  logic          r_run;
  logic [N-1:0]  r_addr;
  logic [N-1:0]  r_rsp_pc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_disc;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [N-1:0]  r_mem_inst [DEPTH];
  logic [N-1:0]  r_mem_pc   [DEPTH];

  logic          w_room;
  logic          w_accept;
  logic          w_resp;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_out_nxt;
  logic [N-1:0]  w_target;
  logic [N-1:0]  w_head_pc;
  logic [1:0]    w_unused_lo;

  assign w_unused_lo = redirect_pc[1:0];
  assign w_target    = {redirect_pc[N-1:2], 2'b00};

  // Outstanding requests plus buffered entries may never exceed the FIFO size.
  assign w_room    = ({1'b0, r_out} + {1'b0, r_count}) < {1'b0, LP_DEPTH};
  assign imem_req  = r_run & ~redirect & w_room;
  assign imem_addr = r_addr;

  assign w_accept  = imem_req & imem_gnt;
  assign w_resp    = imem_rvalid & (r_out != '0);
  assign w_out_nxt = r_out + CW'(w_accept) - CW'(w_resp);

  assign inst_valid = (r_count != '0);
  assign w_push     = w_resp & ~redirect & (r_disc == '0);
  assign w_pop      = inst_valid & deco_ready & ~redirect;

  // Kept responses are always sequential from the last redirect target, so the
  // response address is tracked by a single counter instead of an address queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run    <= 1'b0;
      r_addr   <= RESET_PC;
      r_rsp_pc <= RESET_PC;
      r_out    <= '0;
      r_disc   <= '0;
      r_count  <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
    end else begin
      r_run <= 1'b1;
      r_out <= w_out_nxt;
      if (redirect) begin
        r_addr   <= w_target;
        r_rsp_pc <= w_target;
        r_disc   <= w_out_nxt;
        r_count  <= '0;
        r_wptr   <= '0;
        r_rptr   <= '0;
      end else begin
        if (w_accept) begin
          r_addr <= r_addr + LP_STEP;
        end
        if (w_resp && (r_disc != '0)) begin
          r_disc <= r_disc - CW'(1);
        end
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + LP_STEP;
          r_wptr   <= r_wptr + AW'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + AW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_inst[r_wptr] <= imem_rdata;
      r_mem_pc[r_wptr]   <= r_rsp_pc;
    end
  end

`ifdef FETCH_PC_PLUS8_EN
  assign w_head_pc = r_mem_pc[r_rptr] + N'(8);
`else
  assign w_head_pc = r_mem_pc[r_rptr];
`endif

  // Outputs read zero while empty so reset and flushed states look identical.
  assign inst = inst_valid ? r_mem_inst[r_rptr] : '0;
  assign pc   = inst_valid ? w_head_pc : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a simple in-order memory model.
module tb_fetch_stage;

`ifdef FETCH_PC_PLUS8_EN
  localparam logic [31:0] OFF = 32'd8;
`else
  localparam logic [31:0] OFF = 32'd0;
`endif

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        deco_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  logic        mem_hold = 1'b0;
  logic [31:0] pend[$];
  logic [63:0] mon_q[$];

  fetch_stage #(.N(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst(inst), .pc(pc), .inst_valid(inst_valid), .deco_ready(deco_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: grants seen before an edge answer right after it, data = 0xE000_0001 + address.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) pend.delete();
      else if (imem_req && imem_gnt) begin
        pend.push_back(imem_addr);
        n_acc++;
      end
      @(posedge clk);
      #2;
      if (!rst_n) begin
        pend.delete();
        imem_rvalid = 1'b0;
      end else if (!mem_hold && pend.size() > 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hE000_0001 + pend.pop_front();
      end else begin
        imem_rvalid = 1'b0;
      end
    end
  end

  always @(negedge clk)
    if (rst_n && inst_valid && deco_ready && !redirect) mon_q.push_back({inst, pc});

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_gnt = 1'b1; deco_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    smp();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h want 0", imem_addr); end
    n_cmp++; if (inst !== 32'h0) begin n_err++; $display("FAIL rst_inst got %h want 0", inst); end
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got %h want 0", pc); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", inst_valid); end
    adv();
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_basic();
    adv(); smp();
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL basic_req0 got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL basic_addr0 got %h want 0", imem_addr); end
    adv(); smp();
    n_cmp++; if (imem_addr !== 32'h4) begin n_err++; $display("FAIL basic_addr1 got %h want 4", imem_addr); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL basic_nobypass got %b want 0", inst_valid); end
    adv(); smp();
    n_cmp++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL basic_addr2 got %h want 8", imem_addr); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL basic_full_req got %b want 0", imem_req); end
    n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %b want 1", inst_valid); end
    n_cmp++; if (inst !== 32'hE000_0001) begin n_err++; $display("FAIL basic_inst got %h want e0000001", inst); end
    n_cmp++; if (pc !== OFF) begin n_err++; $display("FAIL basic_pc got %h want %h", pc, OFF); end
  endtask

  task automatic test_stall();
    logic [63:0] e;
    for (int i = 0; i < 5; i++) begin
      adv(); smp();
      n_cmp++; if (inst !== 32'hE000_0001) begin n_err++; $display("FAIL stall_inst[%0d] got %h want e0000001", i, inst); end
      n_cmp++; if (pc !== OFF) begin n_err++; $display("FAIL stall_pc[%0d] got %h want %h", i, pc, OFF); end
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req[%0d] got %b want 0", i, imem_req); end
      n_cmp++; if (pend.size() > 2) begin n_err++; $display("FAIL stall_outstanding[%0d] got %0d want <=2", i, pend.size()); end
    end
    adv();
    deco_ready = 1'b1;
    mon_q.delete();
    repeat (12) adv();
    smp();
    n_cmp++; if (mon_q.size() < 4) begin n_err++; $display("FAIL stall_count got %0d want >=4", mon_q.size()); end
    for (int k = 0; k < 4 && k < mon_q.size(); k++) begin
      e = mon_q[k];
      n_cmp++; if (e[63:32] !== 32'hE000_0001 + 32'(4 * k)) begin n_err++; $display("FAIL stall_seq_inst[%0d] got %h want %h", k, e[63:32], 32'hE000_0001 + 32'(4 * k)); end
      n_cmp++; if (e[31:0] !== 32'(4 * k) + OFF) begin n_err++; $display("FAIL stall_seq_pc[%0d] got %h want %h", k, e[31:0], 32'(4 * k) + OFF); end
    end
  endtask

  task automatic test_redirect();
    logic [63:0] e;
    adv();
    mem_hold = 1'b1;
    repeat (6) adv();
    smp();
    n_cmp++; if (pend.size() != 2) begin n_err++; $display("FAIL redir_inflight got %0d want 2", pend.size()); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_pre_valid got %b want 0", inst_valid); end
    adv();
    redirect = 1'b1; redirect_pc = 32'h100;
    mon_q.delete();
    smp();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL redir_req got %b want 0", imem_req); end
    adv();
    redirect = 1'b0; mem_hold = 1'b0;
    smp();
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid_after got %b want 0", inst_valid); end
    n_cmp++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL redir_addr got %h want 100", imem_addr); end
    for (int i = 0; i < 2; i++) begin
      adv(); smp();
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_drop[%0d] got %b want 0", i, inst_valid); end
    end
    adv(); smp();
    n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL redir_new_valid got %b want 1", inst_valid); end
    n_cmp++; if (inst !== 32'hE000_0101) begin n_err++; $display("FAIL redir_new_inst got %h want e0000101", inst); end
    n_cmp++; if (pc !== 32'h100 + OFF) begin n_err++; $display("FAIL redir_new_pc got %h want %h", pc, 32'h100 + OFF); end
    repeat (4) adv();
    smp();
    n_cmp++; if (mon_q.size() < 2) begin n_err++; $display("FAIL redir_mon_count got %0d want >=2", mon_q.size()); end
    if (mon_q.size() >= 2) begin
      e = mon_q[1];
      n_cmp++; if (e[31:0] !== 32'h104 + OFF) begin n_err++; $display("FAIL redir_second_pc got %h want %h", e[31:0], 32'h104 + OFF); end
    end
  endtask

  task automatic test_gnt_hold();
    int acc0;
    logic [63:0] e;
    adv();
    imem_gnt = 1'b0;
    repeat (4) adv();
    redirect = 1'b1; redirect_pc = 32'h203;
    smp();
    adv();
    redirect = 1'b0;
    acc0 = n_acc;
    mon_q.delete();
    for (int i = 0; i < 3; i++) begin
      smp();
      n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL gnt_req[%0d] got %b want 1", i, imem_req); end
      n_cmp++; if (imem_addr !== 32'h200) begin n_err++; $display("FAIL gnt_addr[%0d] got %h want 200", i, imem_addr); end
      adv();
    end
    imem_gnt = 1'b1;
    adv();
    imem_gnt = 1'b0;
    smp();
    n_cmp++; if (imem_addr !== 32'h204) begin n_err++; $display("FAIL gnt_step_addr got %h want 204", imem_addr); end
    n_cmp++; if (n_acc - acc0 != 1) begin n_err++; $display("FAIL gnt_one_accept got %0d want 1", n_acc - acc0); end
    adv(); smp(); adv(); smp();
    n_cmp++; if (imem_addr !== 32'h204) begin n_err++; $display("FAIL gnt_hold_addr got %h want 204", imem_addr); end
    n_cmp++; if (n_acc - acc0 != 1) begin n_err++; $display("FAIL gnt_hold_accept got %0d want 1", n_acc - acc0); end
    n_cmp++; if (mon_q.size() < 1) begin n_err++; $display("FAIL gnt_mon_count got %0d want >=1", mon_q.size()); end
    if (mon_q.size() >= 1) begin
      e = mon_q[0];
      n_cmp++; if (e[63:32] !== 32'hE000_0201) begin n_err++; $display("FAIL gnt_inst got %h want e0000201", e[63:32]); end
      n_cmp++; if (e[31:0] !== 32'h200 + OFF) begin n_err++; $display("FAIL gnt_pc got %h want %h", e[31:0], 32'h200 + OFF); end
    end
  endtask

  task automatic test_redirect_collide();
    adv();
    imem_gnt = 1'b1; deco_ready = 1'b0;
    adv();
    adv();
    deco_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
    smp();
    n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL col_pre_valid got %b want 1", inst_valid); end
    adv();
    redirect = 1'b0;
    mon_q.delete();
    smp();
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL col_empty got %b want 0", inst_valid); end
    n_cmp++; if (imem_addr !== 32'h300) begin n_err++; $display("FAIL col_addr got %h want 300", imem_addr); end
    adv(); smp();
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL col_dropped got %b want 0", inst_valid); end
    adv(); smp();
    n_cmp++; if (inst !== 32'hE000_0301) begin n_err++; $display("FAIL col_inst got %h want e0000301", inst); end
    n_cmp++; if (pc !== 32'h300 + OFF) begin n_err++; $display("FAIL col_pc got %h want %h", pc, 32'h300 + OFF); end
  endtask

  task automatic test_reset_mid();
    adv();
    imem_gnt = 1'b0;
    repeat (3) adv();
    imem_gnt = 1'b1;
    adv();
    imem_gnt = 1'b0; mem_hold = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rmid_req got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rmid_addr got %h want 0", imem_addr); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %b want 0", inst_valid); end
    n_cmp++; if (inst !== 32'h0) begin n_err++; $display("FAIL rmid_inst got %h want 0", inst); end
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL rmid_pc got %h want 0", pc); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; mem_hold = 1'b0; imem_gnt = 1'b1;
    smp();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rmid_req_pre got %b want 0", imem_req); end
    adv(); smp();
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rmid_restart_req got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rmid_restart_addr got %h want 0", imem_addr); end
    adv(); smp();
    n_cmp++; if (imem_addr !== 32'h4) begin n_err++; $display("FAIL rmid_addr1 got %h want 4", imem_addr); end
    adv(); smp();
    n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL rmid_valid1 got %b want 1", inst_valid); end
    n_cmp++; if (inst !== 32'hE000_0001) begin n_err++; $display("FAIL rmid_inst1 got %h want e0000001", inst); end
    n_cmp++; if (pc !== OFF) begin n_err++; $display("FAIL rmid_pc1 got %h want %h", pc, OFF); end
  endtask

  initial begin
    test_reset();
    test_fetch_basic();
    test_stall();
    test_redirect();
    test_gnt_hold();
    test_redirect_collide();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
